memory_responder: RTL and testbench

Data/instruction memory responder serving the multicycle RV32I core's memory requests. Accepts one request at a time over a valid/ready handshake, waits a fixed number of cycles, then performs the access on an internal word-organised RAM. Stores use byte-lane encoding and loads use sign/zero extension, both driven by the instruction's funct3 as presented by the core. Sits between the core's fetch/memory stages and the RAM array.

---
 rtl/memory_access_pkg.sv | 23 ++
 rtl/memory_lane_formatter.sv | 89 ++++++++
 rtl/memory_responder.sv | 127 ++++++++++++
 tb/tb_memory_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared encodings for the memory responder: FSM states and the funct3
// load/store type codes presented by the RV32I core.
package memory_access_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Load funct3 codes (match load_memory_decoder_type)
  localparam logic [2:0] LOAD_BYTE          = 3'b000;
  localparam logic [2:0] LOAD_HALF          = 3'b001;
  localparam logic [2:0] LOAD_WORD          = 3'b010;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
  localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;

  // Store funct3[1:0] codes (match store_memory_encoder_type)
  localparam logic [1:0] STORE_BYTE = 2'b00;
  localparam logic [1:0] STORE_HALF = 2'b01;
  localparam logic [1:0] STORE_WORD = 2'b10;

endpackage

// File: rtl/memory_lane_formatter.sv
// Byte-lane formatting for the memory responder: store byte enables and
// replicated store data, load lane extraction with sign/zero extension, and
// detection of illegal or misaligned accesses.
// Optional feature: define MEMORY_RESPONDER_MISALIGN_TRAP_EN to flag
// misaligned halfword/word accesses as errors instead of ignoring low bits.
module memory_lane_formatter
  import memory_access_pkg::*;
(
  input  logic        write,
  input  logic [1:0]  offset,
  input  logic [2:0]  access_type,
  input  logic [31:0] write_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_enable,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        error
);

  logic        illegal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Classify the access: unknown type codes and (optionally) misalignment
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (write) begin
      illegal = (access_type[1:0] == 2'b11);
    end else begin
      case (access_type)
        LOAD_BYTE, LOAD_HALF, LOAD_WORD,
        LOAD_BYTE_UNSIGNED, LOAD_HALF_UNSIGNED: illegal = 1'b0;
        default:                                illegal = 1'b1;
      endcase
    end
`ifdef MEMORY_RESPONDER_MISALIGN_TRAP_EN
    // Size is funct3[1:0] for both loads and stores
    if (access_type[1:0] == 2'b01)
      misaligned = offset[0];
    else if (access_type[1:0] == 2'b10)
      misaligned = (offset != 2'b00);
`endif
    error = illegal | misaligned;
  end

  // Store side: lane enables plus data replicated onto every candidate lane
  always_comb begin
    byte_enable = 4'b0000;
    store_data  = write_data;
    case (access_type[1:0])
      STORE_BYTE: begin
        byte_enable = 4'b0001 << offset;
        store_data  = {4{write_data[7:0]}};
      end
      STORE_HALF: begin
        byte_enable = offset[1] ? 4'b1100 : 4'b0011;
        store_data  = {2{write_data[15:0]}};
      end
      STORE_WORD: begin
        byte_enable = 4'b1111;
        store_data  = write_data;
      end
      default: byte_enable = 4'b0000;
    endcase
    if (!write || error)
      byte_enable = 4'b0000;
  end

  // Load side: pick the addressed lane, then extend to 32 bits
  always_comb begin
    byte_sel  = read_word[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? read_word[31:16] : read_word[15:0];
    load_data = 32'h0;
    case (access_type)
      LOAD_BYTE:          load_data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_HALF:          load_data = {{16{half_sel[15]}}, half_sel};
      LOAD_WORD:          load_data = read_word;
      LOAD_BYTE_UNSIGNED: load_data = {24'h0, byte_sel};
      LOAD_HALF_UNSIGNED: load_data = {16'h0, half_sel};
      default:            load_data = 32'h0;
    endcase
    if (write || error)
      load_data = 32'h0;
  end

endmodule

// File: rtl/memory_responder.sv
// Memory responder for the multicycle RV32I core: accepts one request at a
// time, waits LATENCY cycles, then performs the access on a word RAM and
// holds the response until the requester takes it.
// Optional feature: MEMORY_RESPONDER_MISALIGN_TRAP_EN (see memory_lane_formatter).
module memory_responder
  import memory_access_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t state, next_state;

  logic [CNT_W-1:0]   counter;
  logic               write_q;
  logic [IDX_W+1:0]   address_q;
  logic [2:0]         type_q;
  logic [31:0]        write_data_q;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] read_word;
  logic [3:0]  byte_enable;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        error;
  logic        accept;
  logic        access;

  // High-order address bits select nothing: accesses wrap modulo RAM size
  logic unused_address_bits;
  assign unused_address_bits = ^req_address[31:IDX_W+2];

  assign accept    = (state == IDLE) && req_valid;
  assign access    = (state == WAIT) && (counter == '0) && !reset;
  assign read_word = mem[address_q[IDX_W+1:2]];

  memory_lane_formatter u_formatter (
    .write       (write_q),
    .offset      (address_q[1:0]),
    .access_type (type_q),
    .write_data  (write_data_q),
    .read_word   (read_word),
    .byte_enable (byte_enable),
    .store_data  (store_data),
    .load_data   (load_data),
    .error       (error)
  );

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid)       next_state = WAIT;
      WAIT:    if (counter == '0)   next_state = RESPOND;
      RESPOND: if (resp_ready)      next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    resp_valid = (state == RESPOND);
  end

  // Request latches, latency counter and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      counter        <= '0;
      write_q        <= 1'b0;
      address_q      <= '0;
      type_q         <= 3'b000;
      write_data_q   <= 32'h0;
      resp_read_data <= 32'h0;
      resp_error     <= 1'b0;
    end else begin
      if (accept) begin
        write_q      <= req_write;
        address_q    <= req_address[IDX_W+1:0];
        type_q       <= req_type;
        write_data_q <= req_write_data;
        counter      <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT && counter != '0) begin
        counter <= counter - 1'b1;
      end
      if (access) begin
        resp_read_data <= load_data;
        resp_error     <= error;
      end
    end
  end

  // Byte-lane RAM write at the access edge
  // NOTE: the RAM array is deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    if (access) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byte_enable[lane])
          mem[address_q[IDX_W+1:2]][lane*8 +: 8] <= store_data[lane*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed testbench for memory_responder (DEPTH_WORDS=4096, LATENCY=2).
module tb_memory_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_address = 32'h0;
  logic [2:0]  req_type = 3'b000;
  logic [31:0] req_write_data = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_read_data;
  logic        resp_error;

  int tests = 0;
  int fails = 0;

  memory_responder #(.DEPTH_WORDS(4096), .LATENCY(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_type       (req_type),
    .req_write_data (req_write_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_read_data (resp_read_data),
    .resp_error     (resp_error)
  );

  always #5 clk = ~clk;

  // One complete transaction with resp_ready high; returns at the negedge
  // where the response is visible. lat = edges from acceptance to resp_valid.
  task automatic transact(input logic wr, input logic [31:0] addr, input logic [2:0] ty,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat);
    int guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_write = wr; req_address = addr; req_type = ty; req_write_data = wd;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = resp_read_data;
    er = resp_error;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    tests++; if (resp_read_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", resp_read_data); end
    tests++; if (resp_error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", resp_error); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got %b want 1", req_ready); end
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 32'h100, 3'b010, 32'hDEADBEEF, rd, er, lat);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL sw_latency got %0d want %0d", lat, LAT); end
    tests++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL sw_resp got %h/%b want 0/0", rd, er); end
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_return got %b want 1", req_ready); end
    transact(1'b0, 32'h100, 3'b010, 32'h0, rd, er, lat);
    tests++; if (lat !== LAT) begin fails++; $display("FAIL lw_latency got %0d want %0d", lat, LAT); end
    tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL lw_data got %h/%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_bytes();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 32'h100, 3'b010, 32'h0, rd, er, lat);
    transact(1'b1, 32'h101, 3'b000, 32'hAAAA_AA12, rd, er, lat);
    transact(1'b0, 32'h101, 3'b000, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'h0000_0012) begin fails++; $display("FAIL lb_101 got %h want 00000012", rd); end
    transact(1'b1, 32'h103, 3'b000, 32'h0000_0080, rd, er, lat);
    transact(1'b0, 32'h103, 3'b000, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_103 got %h want ffffff80", rd); end
    transact(1'b0, 32'h103, 3'b100, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'h0000_0080) begin fails++; $display("FAIL lbu_103 got %h want 00000080", rd); end
    transact(1'b1, 32'h100, 3'b000, 32'h0000_00EF, rd, er, lat);
    transact(1'b0, 32'h100, 3'b010, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'h8000_12EF) begin fails++; $display("FAIL lw_bytes got %h want 800012ef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 32'h200, 3'b010, 32'h0, rd, er, lat);
    transact(1'b1, 32'h202, 3'b001, 32'h1234_BEEF, rd, er, lat);
    transact(1'b0, 32'h202, 3'b001, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'hFFFF_BEEF) begin fails++; $display("FAIL lh_202 got %h want ffffbeef", rd); end
    transact(1'b0, 32'h202, 3'b101, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_202 got %h want 0000beef", rd); end
    transact(1'b0, 32'h200, 3'b010, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'hBEEF_0000) begin fails++; $display("FAIL lw_half got %h want beef0000", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int guard = 0;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h200; req_type = 3'b010;
    @(posedge clk); @(negedge clk);
    // A different request presented while busy must be ignored
    req_write = 1'b1; req_write_data = 32'h0;
    while (!resp_valid && guard < 20) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (resp_valid !== 1'b1 || resp_read_data !== 32'hBEEF_0000 || resp_error !== 1'b0 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d got v=%b d=%h e=%b r=%b want 1/beef0000/0/0",
                 i, resp_valid, resp_read_data, resp_error, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL release got r=%b v=%b want 1/0", req_ready, resp_valid); end
    transact(1'b0, 32'h200, 3'b010, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'hBEEF_0000) begin fails++; $display("FAIL ignored_req got %h want beef0000", rd); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int lat;
    transact(1'b0, 32'h200, 3'b011, 32'h0, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL load_011 got %h/%b want 0/1", rd, er); end
    transact(1'b0, 32'h200, 3'b111, 32'h0, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL load_111 got %h/%b want 0/1", rd, er); end
    transact(1'b1, 32'h200, 3'b011, 32'hFFFF_FFFF, rd, er, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL store_11 got err %b want 1", er); end
    transact(1'b0, 32'h200, 3'b010, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'hBEEF_0000 || er !== 1'b0) begin fails++; $display("FAIL store_11_nowrite got %h want beef0000", rd); end
`ifdef MEMORY_RESPONDER_MISALIGN_TRAP_EN
    transact(1'b1, 32'h102, 3'b010, 32'hA5A5_A5A5, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL sw_misaligned got %h/%b want 0/1", rd, er); end
    transact(1'b0, 32'h100, 3'b010, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'h8000_12EF) begin fails++; $display("FAIL sw_misaligned_nowrite got %h want 800012ef", rd); end
    transact(1'b0, 32'h203, 3'b001, 32'h0, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL lh_misaligned got %h/%b want 0/1", rd, er); end
`else
    transact(1'b1, 32'h102, 3'b010, 32'hA5A5_A5A5, rd, er, lat);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL sw_unaligned_err got %b want 0", er); end
    transact(1'b0, 32'h100, 3'b010, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sw_unaligned_word got %h want a5a5a5a5", rd); end
    transact(1'b0, 32'h203, 3'b001, 32'h0, rd, er, lat);
    tests++; if (er !== 1'b0 || rd !== 32'hFFFF_BEEF) begin fails++; $display("FAIL lh_unaligned got %h/%b want ffffbeef/0", rd, er); end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 32'h0000_4300, 3'b010, 32'hCAFE_F00D, rd, er, lat);
    transact(1'b0, 32'h0000_0300, 3'b010, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL wrap got %h want cafef00d", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h300; req_type = 3'b010;
    req_write_data = 32'h5555_5555;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_read_data !== 32'h0 || resp_error !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs got r=%b v=%b d=%h e=%b want 0/0/0/0",
               req_ready, resp_valid, resp_read_data, resp_error);
    end
    reset = 1'b0;
    @(negedge clk);
    transact(1'b0, 32'h300, 3'b010, 32'h0, rd, er, lat);
    tests++; if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL mid_reset_nowrite got %h want cafef00d", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_bytes();
    test_half();
    test_backpressure();
    test_error();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
